// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with built-in baud divider and input FIFO
//
// Purpose: serialises words from a FIFO onto a UART line with configurable
// payload width, parity mode and stop-bit count. Frames leave back-to-back
// with no idle gap while the FIFO holds data.
//
// Ports:
//   clk        - system clock, all logic on the rising edge
//   rst        - synchronous active-high reset (aborts frame, flushes FIFO)
//   data_in    - word to transmit
//   data_valid - data_in is valid; accepted when data_ready is high
//   data_ready - FIFO can accept a word (not full)
//   tx         - registered serial output, idle high
//   tx_busy    - a frame is in progress
//   fifo_count - number of words currently held in the FIFO
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV    = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_parity;

    // ------------------------------------------------------------------
    // Transmit state
    // ------------------------------------------------------------------
    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bit;
    logic                 tx_r;
    logic                 baud_last;
    logic                 stop_end;

    assign fifo_empty = (count == '0);
    assign data_ready = (count != FULL_CNT);
    assign fifo_count = count;
    assign head       = mem[rd_ptr];

    // Odd parity makes the total number of ones (payload + parity) odd.
    assign head_parity = (PARITY == 1) ? ~(^head) : (^head);

    assign baud_last = (baud_cnt == BAUD_LAST);

    // Last clock of the final stop bit: the frame ends on this edge.
    assign stop_end = (state == S_STOP) && baud_last && (bit_cnt == STOP_LAST);

    // Reset wins over any push or pop on the same edge.
    assign push = data_valid && data_ready && !rst;
    assign pop  = !rst && !fifo_empty && ((state == S_IDLE) || stop_end);

    // Storage array carries no reset; only the pointers and count do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer. The baud counter is cleared at every bit boundary,
    // so each bit is exactly DIV clocks and nothing accumulates in a frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tx_r       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_r <= 1'b1;
                    if (pop) begin
                        shift      <= head;
                        parity_bit <= head_parity;
                        bit_cnt    <= '0;
                        baud_cnt   <= '0;
                        tx_r       <= 1'b0;
                        state      <= S_START;
                    end
                end

                S_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_r     <= shift[0];
                        shift    <= shift >> 1;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                tx_r  <= parity_bit;
                                state <= S_PARITY;
                            end else begin
                                tx_r  <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_r    <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_r     <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            // Chain straight into the next start bit when
                            // data is waiting, so no idle clock appears.
                            if (pop) begin
                                shift      <= head;
                                parity_bit <= head_parity;
                                tx_r       <= 1'b0;
                                state      <= S_START;
                            end else begin
                                tx_r  <= 1'b1;
                                state <= S_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    tx_r  <= 1'b1;
                end
            endcase
        end
    end

    assign tx      = tx_r;
    assign tx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic [3:0] rst;
    logic [3:0] valid;
    logic [3:0] ready_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [8:0] din [4];
    logic [2:0] cnt [4];

    logic [8:0] sbq [4][$];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // u0: 8N1, depth 4; u1: 8E1; u2: 8O1; u3: 9N2. All DIV = 10.
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst[0]), .data_in(din[0][7:0]), .data_valid(valid[0]),
        .data_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst[1]), .data_in(din[1][7:0]), .data_valid(valid[1]),
        .data_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst[2]), .data_in(din[2][7:0]), .data_valid(valid[2]),
        .data_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(9),
                   .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst[3]), .data_in(din[3]), .data_valid(valid[3]),
        .data_ready(ready_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .fifo_count(cnt[3]));

    function automatic int db_of(input int i);
        return (i == 3) ? 9 : 8;
    endfunction

    function automatic int par_of(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int sb_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int flen(input int i);
        return (1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i)) * 10;
    endfunction

    // Expected line level for bit slot b of a frame carrying word w.
    function automatic logic exp_bit(input int i, input logic [8:0] w, input int b);
        int db;
        int p;
        db = db_of(i);
        p  = par_of(i);
        if (b == 0) return 1'b0;
        if (b <= db) return w[b-1];
        if (p != 0 && b == db + 1) return (p == 2) ? (^w) : ~(^w);
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; holds data for the following posedge.
    task automatic push(input int i, input logic [8:0] d, input logic exp_rdy);
        logic [8:0] w;
        w = (db_of(i) == 9) ? d : {1'b0, d[7:0]};
        din[i]   = d;
        valid[i] = 1'b1;
        chk("ready", {31'd0, ready_v[i]}, {31'd0, exp_rdy});
        if (exp_rdy) sbq[i].push_back(w);
        @(negedge clk);
    endtask

    task automatic stop_push(input int i);
        valid[i] = 1'b0;
        din[i]   = '0;
    endtask

    // Waits for a start bit, then checks n contiguous frames clock by clock.
    task automatic check_frames(input int i, input int n,
                                output int busy_clks, output logic [15:0] obs);
        int t;
        int bad;
        int len;
        logic [8:0] w;
        busy_clks = 0;
        obs = '0;
        t = 0;
        while (tx_v[i] !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_start", {31'd0, t < 3000}, 32'd1);
        if (t >= 3000) return;
        len = flen(i);
        for (int f = 0; f < n; f++) begin
            bad = 0;
            chk("sb_nonempty", {31'd0, sbq[i].size() > 0}, 32'd1);
            w = (sbq[i].size() > 0) ? sbq[i].pop_front() : 9'h0;
            obs = '0;
            for (int c = 0; c < len; c++) begin
                if (tx_v[i] !== exp_bit(i, w, c / 10)) bad++;
                if (c % 10 == 5) obs[c/10] = tx_v[i];
                if (busy_v[i] === 1'b1) busy_clks++;
                @(negedge clk);
            end
            chk("frame", bad, 0);
        end
        t = 0;
        while (busy_v[i] === 1'b1 && t < 3000) begin
            busy_clks++;
            @(negedge clk);
            t++;
        end
        chk("idle_tx", {31'd0, tx_v[i]}, 32'd1);
    endtask

    typedef struct {
        int         inst;
        logic [8:0] data;
        int         exp_busy;
        bit         chk_par;
        logic       exp_par;
    } frame_vec_t;

    typedef struct {
        logic [8:0] data;
        logic       exp_ready;
        logic [2:0] exp_count;
    } fill_vec_t;

    frame_vec_t fv [6];
    fill_vec_t  fl [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        logic [15:0] ob;

        fv[0] = '{1, 9'h0A5, 110, 1'b1, 1'b0};
        fv[1] = '{2, 9'h0A5, 110, 1'b1, 1'b1};
        fv[2] = '{1, 9'h007, 110, 1'b1, 1'b1};
        fv[3] = '{2, 9'h001, 110, 1'b1, 1'b0};
        fv[4] = '{3, 9'h1FF, 120, 1'b0, 1'b0};
        fv[5] = '{3, 9'h100, 120, 1'b0, 1'b0};

        fl[0] = '{9'h0B1, 1'b1, 3'd1};
        fl[1] = '{9'h0B2, 1'b1, 3'd2};
        fl[2] = '{9'h0B3, 1'b1, 3'd3};
        fl[3] = '{9'h0B4, 1'b1, 3'd4};
        fl[4] = '{9'h0C5, 1'b0, 3'd4};
        fl[5] = '{9'h0C6, 1'b0, 3'd4};

        // Reset with data_valid asserted: nothing may be accepted.
        rst   = 4'hF;
        valid = 4'hF;
        for (int i = 0; i < 4; i++) din[i] = 9'h1A5;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_tx",    {31'd0, tx_v[i]},    32'd1);
            chk("rst_busy",  {31'd0, busy_v[i]},  32'd0);
            chk("rst_ready", {31'd0, ready_v[i]}, 32'd1);
            chk("rst_count", {29'd0, cnt[i]},     32'd0);
        end
        rst   = 4'h0;
        valid = 4'h0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        @(negedge clk);

        // 8N1 0x55 with first-word latency.
        fork
            begin
                push(0, 9'h055, 1'b1);
                stop_push(0);
                chk("lat_count0", {29'd0, cnt[0]},     32'd1);
                chk("lat_tx0",    {31'd0, tx_v[0]},    32'd1);
                chk("lat_busy0",  {31'd0, busy_v[0]},  32'd0);
                @(negedge clk);
                chk("lat_tx1",    {31'd0, tx_v[0]},    32'd0);
                chk("lat_busy1",  {31'd0, busy_v[0]},  32'd1);
                chk("lat_count1", {29'd0, cnt[0]},     32'd0);
            end
            check_frames(0, 1, bc, ob);
        join
        chk("busy_8n1", bc, 100);
        chk("bits_8n1", {22'd0, ob[9:0]}, 32'h2AA);
        repeat (3) @(negedge clk);

        // Single-frame vectors across the parity and 9N2 instances.
        for (int k = 0; k < 6; k++) begin
            fork
                begin
                    push(fv[k].inst, fv[k].data, 1'b1);
                    stop_push(fv[k].inst);
                end
                check_frames(fv[k].inst, 1, bc, ob);
            join
            chk("busy_len", bc, fv[k].exp_busy);
            if (fv[k].chk_par) chk("parity_bit", {31'd0, ob[9]}, {31'd0, fv[k].exp_par});
            repeat (3) @(negedge clk);
        end

        // Back-to-back frames.
        fork
            begin
                push(0, 9'h001, 1'b1);
                push(0, 9'h002, 1'b1);
                push(0, 9'h003, 1'b1);
                stop_push(0);
            end
            check_frames(0, 3, bc, ob);
        join
        chk("busy_b2b", bc, 300);
        repeat (3) @(negedge clk);

        // Fill a depth-4 FIFO while the line is busy.
        fork
            begin
                push(0, 9'h0A0, 1'b1);
                for (int k = 0; k < 6; k++) begin
                    push(0, fl[k].data, fl[k].exp_ready);
                    chk("fill_count", {29'd0, cnt[0]}, {29'd0, fl[k].exp_count});
                end
                stop_push(0);
                chk("full_ready", {31'd0, ready_v[0]}, 32'd0);
            end
            check_frames(0, 5, bc, ob);
        join
        chk("busy_fill", bc, 500);
        repeat (3) @(negedge clk);

        // Reset in the middle of data bit 3 with two words queued.
        push(0, 9'h011, 1'b1);
        push(0, 9'h022, 1'b1);
        push(0, 9'h033, 1'b1);
        stop_push(0);
        repeat (42) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy_v[0]}, 32'd1);
        rst[0]   = 1'b1;
        valid[0] = 1'b1;
        din[0]   = 9'h0AA;
        @(negedge clk);
        chk("mid_rst_tx",    {31'd0, tx_v[0]},   32'd1);
        chk("mid_rst_busy",  {31'd0, busy_v[0]}, 32'd0);
        chk("mid_rst_count", {29'd0, cnt[0]},    32'd0);
        rst[0] = 1'b0;
        stop_push(0);
        sbq[0].delete();
        begin
            int lows;
            lows = 0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) lows++;
            end
            chk("post_rst_quiet", lows, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
